// File: rtl/gearbox_pkg.sv
// Shared types and helpers for the 2:1 AXI-Stream gearbox pair (split and merge).
//
// Contents:
//   split_state_t  - state encoding for the downsizing path
//   GB_MAX_W       - widest padded beat the helpers accept
//   half_sel()     - picks the first- or second-emitted half of a wide beat
package gearbox_pkg;

    typedef enum logic [1:0] {ST_EMPTY, ST_FIRST, ST_SECOND} split_state_t;

    // Helpers work on beats zero-padded to this width so one function serves every
    // parameterisation; callers must keep 2*OUT_WORDS*WORD_W at or below it.
    localparam int unsigned GB_MAX_W = 1024;

    // Returns the padded beat shifted so the selected half sits in the low half_w bits.
    // Little-endian order emits the lower half first; big-endian emits the upper half
    // first. Word order within a half is untouched.
    function automatic logic [GB_MAX_W-1:0] half_sel(
        input logic [GB_MAX_W-1:0] data,
        input int unsigned         half_w,
        input logic                big_endian,
        input logic                second
    );
        return (big_endian ^ second) ? (data >> half_w) : data;
    endfunction

endpackage

// File: rtl/axis_gearbox_2to1_split.sv
// Single-clock AXI-Stream 2:1 downsizer. Each accepted input beat of 2*OUT_WORDS words is
// replayed as two output beats of OUT_WORDS words. A packet's final beat may carry only
// its first-emitted half (i_thalf with i_tlast), in which case the second half is dropped.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_tdata/i_tlast/    wide input beat, end of packet, "only first half valid"
//   i_thalf/i_tvalid/
//   i_tready
//   o_tdata/o_tlast/    narrow output beat with AXI handshake
//   o_tvalid/o_tready
//   o_busy              a beat is held internally
module axis_gearbox_2to1_split
    import gearbox_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int OUT_WORDS  = 1,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*OUT_WORDS*WORD_W-1:0] i_tdata,
    input  logic                      i_tlast,
    input  logic                      i_thalf,
    input  logic                      i_tvalid,
    output logic                      i_tready,
    output logic [OUT_WORDS*WORD_W-1:0] o_tdata,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic                      o_busy
);

    localparam int OUT_W = OUT_WORDS * WORD_W;
    localparam int IN_W  = 2 * OUT_W;

    split_state_t     state_q, state_d;
    logic [IN_W-1:0]  hold_data_q;
    logic             hold_last_q;
    logic             hold_half_q;
    logic             load;
    logic             sel_second;
    logic             tail_only;

    // Short tail: the held beat ends the packet after its first half.
    assign tail_only = hold_last_q & hold_half_q;

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        i_tready   = 1'b0;
        o_tvalid   = 1'b0;
        o_tlast    = 1'b0;
        sel_second = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                i_tready = 1'b1;
                if (i_tvalid) begin
                    load    = 1'b1;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST: begin
                o_tvalid = 1'b1;
                o_tlast  = tail_only;
                if (o_tready) begin
                    state_d = tail_only ? ST_EMPTY : ST_SECOND;
                end
            end
            ST_SECOND: begin
                o_tvalid   = 1'b1;
                o_tlast    = hold_last_q;
                sel_second = 1'b1;
                // Ready passes straight through so a new beat replaces the old one
                // on the same edge the last half leaves, with no idle cycle.
                i_tready   = o_tready;
                if (o_tready) begin
                    if (i_tvalid) begin
                        load    = 1'b1;
                        state_d = ST_FIRST;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output comes only from the hold register, never from i_tdata; forced to zero
    // while idle so stale data is not left on the bus.
    always_comb begin
        o_tdata = '0;
        if (o_tvalid) begin
            o_tdata = OUT_W'(half_sel(GB_MAX_W'(hold_data_q), OUT_W, BIG_ENDIAN, sel_second));
        end
    end

    assign o_busy = (state_q != ST_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_half_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                hold_data_q <= i_tdata;
                hold_last_q <= i_tlast;
                hold_half_q <= i_thalf;
            end
        end
    end

endmodule

// File: tb/tb_axis_gearbox_2to1_split.sv
// Self-checking bench for axis_gearbox_2to1_split. A reference model pushes the expected
// narrow beats when an input beat is accepted; a negedge monitor pops and compares them
// on each output handshake, and also checks hold stability and streaming behaviour.
module tb_axis_gearbox_2to1_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_tdata;
    logic        i_tlast, i_thalf, i_tvalid, i_tready;
    logic [15:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready, o_busy;

    logic        rnd_mode, o_rdy_man, o_rdy_rnd;
    assign o_tready = rnd_mode ? o_rdy_rnd : o_rdy_man;

    // Secondary instances: big-endian 1-word and big-endian 2-word variants.
    logic [31:0] b_i_tdata;
    logic [63:0] w_i_tdata;
    logic        x_tlast, x_tvalid;
    logic        b_i_tready, b_o_tlast, b_o_tvalid, b_o_busy;
    logic [15:0] b_o_tdata;
    logic        w_i_tready, w_o_tlast, w_o_tvalid, w_o_busy;
    logic [31:0] w_o_tdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    logic        stalled = 1'b0;
    logic [15:0] st_data;
    logic        st_last;
    logic        stream_chk = 1'b0;
    logic        prev_rdy = 1'b0;

    always #5 clk = ~clk;

    axis_gearbox_2to1_split #(.WORD_W(16), .OUT_WORDS(1), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_thalf(i_thalf),
        .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .o_busy(o_busy)
    );

    axis_gearbox_2to1_split #(.WORD_W(16), .OUT_WORDS(1), .BIG_ENDIAN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(b_i_tdata), .i_tlast(x_tlast), .i_thalf(1'b0),
        .i_tvalid(x_tvalid), .i_tready(b_i_tready),
        .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid),
        .o_tready(1'b1), .o_busy(b_o_busy)
    );

    axis_gearbox_2to1_split #(.WORD_W(16), .OUT_WORDS(2), .BIG_ENDIAN(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .i_tdata(w_i_tdata), .i_tlast(x_tlast), .i_thalf(1'b0),
        .i_tvalid(x_tvalid), .i_tready(w_i_tready),
        .o_tdata(w_o_tdata), .o_tlast(w_o_tlast), .o_tvalid(w_o_tvalid),
        .o_tready(1'b1), .o_busy(w_o_busy)
    );

    always begin
        @(posedge clk);
        #1;
        o_rdy_rnd = ($urandom_range(0, 99) < 30);
    end

    // Monitor / scoreboard, sampled mid-cycle when all handshake signals are settled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                n_cmp++;
                assert (o_tvalid === 1'b1 && o_tdata === st_data && o_tlast === st_last)
                else begin
                    n_err++;
                    $error("FAIL hold_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                           o_tvalid, o_tdata, o_tlast, st_data, st_last);
                end
            end
            if (i_tvalid && i_tready) begin
                // Little-endian model: lower half first, upper half unless short tail.
                if (i_tlast && i_thalf) begin
                    exp_q.push_back('{d: i_tdata[15:0], l: 1'b1});
                end else begin
                    exp_q.push_back('{d: i_tdata[15:0], l: 1'b0});
                    exp_q.push_back('{d: i_tdata[31:16], l: i_tlast});
                end
            end
            if (o_tvalid && o_tready) begin
                n_cmp++;
                assert (exp_q.size() != 0)
                else begin
                    n_err++;
                    $error("FAIL unexpected_out: got d=%h l=%b want no beat", o_tdata, o_tlast);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert (o_tdata === e.d && o_tlast === e.l)
                    else begin
                        n_err++;
                        $error("FAIL out_beat: got d=%h l=%b want d=%h l=%b",
                               o_tdata, o_tlast, e.d, e.l);
                    end
                end
            end
            if (stream_chk) begin
                n_cmp++;
                assert (o_tvalid === 1'b1 && i_tready === ~prev_rdy)
                else begin
                    n_err++;
                    $error("FAIL stream: got v=%b rdy=%b want v=1 rdy=%b",
                           o_tvalid, i_tready, ~prev_rdy);
                end
                prev_rdy = i_tready;
            end
            stalled = o_tvalid && !o_tready;
            st_data = o_tdata;
            st_last = o_tlast;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l, input logic h);
        int cyc = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_thalf  = h;
        i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        assert (i_tready === 1'b1)
        else begin
            n_err++;
            $error("FAIL send_timeout: got i_tready=%b want 1 for beat %h", i_tready, d);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        n_cmp++;
        assert (exp_q.size() == 0)
        else begin
            n_err++;
            $error("FAIL drain: got %0d beats pending want 0", exp_q.size());
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        i_tdata   = '0;
        i_tlast   = 1'b0;
        i_thalf   = 1'b0;
        i_tvalid  = 1'b0;
        rnd_mode  = 1'b0;
        o_rdy_man = 1'b1;
        b_i_tdata = '0;
        w_i_tdata = '0;
        x_tlast   = 1'b0;
        x_tvalid  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_tlast", 64'(o_tlast), 64'd0);
        chk("rst_tdata", 64'(o_tdata), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("tready_after_rst", 64'(i_tready), 64'd1);

        // Big-endian variants, sink always ready
        b_i_tdata = 32'hBBBB_AAAA;
        w_i_tdata = 64'h4444_3333_2222_1111;
        x_tlast   = 1'b1;
        x_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        x_tvalid = 1'b0;
        chk("be1_first", {b_o_tvalid, b_o_tlast, b_o_tdata}, {2'b10, 16'hBBBB});
        chk("be2_first", {w_o_tvalid, w_o_tlast, w_o_tdata}, {2'b10, 32'h4444_3333});
        @(posedge clk);
        #1;
        chk("be1_second", {b_o_tvalid, b_o_tlast, b_o_tdata}, {2'b11, 16'hAAAA});
        chk("be2_second", {w_o_tvalid, w_o_tlast, w_o_tdata}, {2'b11, 32'h2222_1111});
        @(posedge clk);
        #1;
        chk("be_idle", {b_o_tvalid, w_o_tvalid, b_o_busy, w_o_busy}, 64'd0);

        // Single little-endian beat, then o_busy must drop
        send(32'hBBBB_AAAA, 1'b1, 1'b0);
        chk("busy_held", 64'(o_busy), 64'd1);
        drain(20);
        chk("busy_fall", 64'(o_busy), 64'd0);

        // Back-to-back streaming
        send(32'h0001_0000, 1'b0, 1'b0);
        prev_rdy   = 1'b1;
        stream_chk = 1'b1;
        for (int k = 1; k < 8; k++) begin
            send({16'(2 * k + 1), 16'(2 * k)}, (k == 7), 1'b0);
        end
        stream_chk = 1'b0;
        drain(20);

        // Short tail, then thalf without tlast (ignored)
        send(32'h1111_0000, 1'b0, 1'b0);
        send(32'h3333_2222, 1'b1, 1'b1);
        drain(20);
        send(32'h7777_6666, 1'b0, 1'b1);
        send(32'h9999_8888, 1'b1, 1'b0);
        drain(20);

        // Random backpressure
        rnd_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            send($urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain(1000);
        rnd_mode = 1'b0;

        // Async reset while the second half is stalled on the bus
        o_rdy_man = 1'b0;
        send(32'hDEAD_BEEF, 1'b1, 1'b0);
        o_rdy_man = 1'b1;
        @(posedge clk);
        #1;
        o_rdy_man = 1'b0;
        chk("second_held", {o_tvalid, o_tdata}, {1'b1, 16'hDEAD});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {o_tvalid, o_busy, i_tready}, 64'b001);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        o_rdy_man = 1'b1;
        send(32'h5555_4444, 1'b1, 1'b0);
        drain(20);
        @(posedge clk);
        #1;
        chk("final_idle", {o_tvalid, o_busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
